// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the external memory port arbiter: the register-bus
// width used by the core, the default watchdog limit, the arbiter state
// encoding and a small helper that classifies states.
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

  localparam int REG_BUS     = 32;   // core-wide register/bus width
  localparam int TIMEOUT_DEF = 255;  // default watchdog limit in grant cycles

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DGRANT = 2'd1,
    ST_IGRANT = 2'd2
  } arb_state_e;

  // True while a bus transaction is owned by either requester.
  function automatic logic is_grant(input arb_state_e st);
    return (st == ST_DGRANT) || (st == ST_IGRANT);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
// Bundles the fetch port (i_*), the data port (d_*), the stall requests and
// the Wishbone-style external bus (bus_*) of the arbiter.
//   master : arbiter view  (drives acks, read data, stalls, bus command)
//   slave  : environment view (core requesters + external memory slave)
// ---------------------------------------------------------------------------
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = REG_BUS,
  parameter int DATA_W = REG_BUS
);

  localparam int SEL_W = DATA_W / 8;

  // Fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              i_err;

  // Data requester
  logic              d_req;
  logic              d_we;
  logic [SEL_W-1:0]  d_sel;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_err;

  // Pipeline stall requests
  logic              stall_req_if;
  logic              stall_req_mem;

  // External bus
  logic              bus_cyc;
  logic              bus_we;
  logic [SEL_W-1:0]  bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    input  i_req, i_addr,
    input  d_req, d_we, d_sel, d_addr, d_wdata,
    input  bus_rdata, bus_ack,
    output i_rdata, i_ack, i_err,
    output d_rdata, d_ack, d_err,
    output stall_req_if, stall_req_mem,
    output bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata
  );

  modport slave (
    output i_req, i_addr,
    output d_req, d_we, d_sel, d_addr, d_wdata,
    output bus_rdata, bus_ack,
    input  i_rdata, i_ack, i_err,
    input  d_rdata, d_ack, d_err,
    input  stall_req_if, stall_req_mem,
    input  bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata
  );

endinterface

// File: rtl/bus_wdog.sv
// ---------------------------------------------------------------------------
// bus_wdog
// Transaction watchdog. Counts grant cycles that end without a slave ack and
// flags expiry on the cycle whose closing edge would make the count reach
// TIMEOUT, so the arbiter can abort on that same edge.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : reload the counter with zero (held while the arbiter is idle)
//   en       : count this cycle (grant cycle without bus_ack)
//   expire   : this enabled cycle is the TIMEOUT-th unacknowledged one
// ---------------------------------------------------------------------------
module bus_wdog
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int               CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // Counter register: clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = en && (count_r == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Shares one Wishbone-style external memory port between instruction fetch
// and data access. Data has strict priority. Each transaction's bus command is
// registered and held for its whole grant; completion is returned as a
// one-cycle registered ack with registered read data. A watchdog aborts hung
// transactions with ack+err.
// Ports:
//   clk : single clock, rising-edge
//   rst : synchronous active-high reset
//   bif : bus_arbiter_if.master -- fetch/data requesters, stall requests,
//         external bus command/response
// ---------------------------------------------------------------------------
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = REG_BUS,
  parameter int DATA_W  = REG_BUS,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bif
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_e state_r;
  logic       wdog_clr_s;
  logic       wdog_en_s;
  logic       wdog_expire_s;

  // Stall requests follow the requests combinationally and drop with the ack.
  assign bif.stall_req_if  = bif.i_req & ~bif.i_ack;
  assign bif.stall_req_mem = bif.d_req & ~bif.d_ack;

  // Watchdog control: held clear while idle so each grant starts from zero.
  always_comb begin
    wdog_clr_s = 1'b0;
    wdog_en_s  = 1'b0;
    if (is_grant(state_r)) begin
      wdog_en_s = ~bif.bus_ack;
    end else begin
      wdog_clr_s = 1'b1;
    end
  end

  bus_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wdog_clr_s),
    .en     (wdog_en_s),
    .expire (wdog_expire_s)
  );

  // Arbiter FSM with all bus and requester outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      bif.bus_cyc   <= 1'b0;
      bif.bus_we    <= 1'b0;
      bif.bus_sel   <= {SEL_W{1'b0}};
      bif.bus_addr  <= {ADDR_W{1'b0}};
      bif.bus_wdata <= {DATA_W{1'b0}};
      bif.i_rdata   <= {DATA_W{1'b0}};
      bif.d_rdata   <= {DATA_W{1'b0}};
      bif.i_ack     <= 1'b0;
      bif.d_ack     <= 1'b0;
      bif.i_err     <= 1'b0;
      bif.d_err     <= 1'b0;
    end else begin
      // Completion strobes are single-cycle pulses.
      bif.i_ack <= 1'b0;
      bif.d_ack <= 1'b0;
      bif.i_err <= 1'b0;
      bif.d_err <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          // bus_ack seen here belongs to no transaction and is ignored.
          if (bif.d_req) begin
            bif.bus_cyc   <= 1'b1;
            bif.bus_we    <= bif.d_we;
            bif.bus_sel   <= bif.d_sel;
            bif.bus_addr  <= ADDR_W'(bif.d_addr);
            bif.bus_wdata <= DATA_W'(bif.d_wdata);
            state_r       <= ST_DGRANT;
          end else if (bif.i_req) begin
            bif.bus_cyc   <= 1'b1;
            bif.bus_we    <= 1'b0;
            bif.bus_sel   <= {SEL_W{1'b1}};
            bif.bus_addr  <= ADDR_W'(bif.i_addr);
            bif.bus_wdata <= {DATA_W{1'b0}};
            state_r       <= ST_IGRANT;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_DGRANT: begin
          // A dropped d_req (pipeline flush) lets the bus cycle finish but
          // withholds the completion from the requester.
          if (bif.bus_ack) begin
            bif.bus_cyc <= 1'b0;
            state_r     <= ST_IDLE;
            if (bif.d_req) begin
              bif.d_ack   <= 1'b1;
              bif.d_rdata <= bif.bus_we ? {DATA_W{1'b0}} : bif.bus_rdata;
            end
          end else if (wdog_expire_s) begin
            bif.bus_cyc <= 1'b0;
            state_r     <= ST_IDLE;
            if (bif.d_req) begin
              bif.d_ack   <= 1'b1;
              bif.d_err   <= 1'b1;
              bif.d_rdata <= {DATA_W{1'b0}};
            end
          end else begin
            state_r <= ST_DGRANT;
          end
        end

        ST_IGRANT: begin
          if (bif.bus_ack) begin
            bif.bus_cyc <= 1'b0;
            state_r     <= ST_IDLE;
            if (bif.i_req) begin
              bif.i_ack   <= 1'b1;
              bif.i_rdata <= bif.bus_rdata;
            end
          end else if (wdog_expire_s) begin
            bif.bus_cyc <= 1'b0;
            state_r     <= ST_IDLE;
            if (bif.i_req) begin
              bif.i_ack   <= 1'b1;
              bif.i_err   <= 1'b1;
              bif.i_rdata <= {DATA_W{1'b0}};
            end
          end else begin
            state_r <= ST_IGRANT;
          end
        end

        default: begin
          bif.bus_cyc <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter (TIMEOUT = 4). A small slave process acks
// after a programmable number of bus_cyc cycles; each task drives one scenario
// and checks hand-computed values one cycle at a time.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  // Slave model controls: ack in bus_cyc cycle number slave_wait (0 = first),
  // -1 = never; slave_force acks regardless of bus_cyc.
  int   slave_wait  = -1;
  int   slave_cnt   = 0;
  logic slave_force = 1'b0;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif.master)
  );

  always #5 clk = ~clk;

  // Slave: update ack mid-cycle so it is stable at the next rising edge.
  always @(negedge clk) begin
    if (slave_force) bif.bus_ack = 1'b1;
    else if (bif.bus_cyc && (slave_cnt == slave_wait)) bif.bus_ack = 1'b1;
    else bif.bus_ack = 1'b0;
    if (bif.bus_cyc) slave_cnt = slave_cnt + 1;
    else slave_cnt = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bif.bus_cyc, bif.bus_we, bif.i_ack, bif.d_ack, bif.i_err, bif.d_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000000",
               {bif.bus_cyc, bif.bus_we, bif.i_ack, bif.d_ack, bif.i_err, bif.d_err});
    end
    checks++;
    if ({bif.bus_addr, bif.bus_wdata, bif.bus_sel} !== 68'h0) begin
      errors++;
      $display("FAIL reset_cmd got %h exp 0", {bif.bus_addr, bif.bus_wdata, bif.bus_sel});
    end
    checks++;
    if ({bif.i_rdata, bif.d_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h exp 0", {bif.i_rdata, bif.d_rdata});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait_load();
    int stall_n = 0;
    slave_wait    = 0;
    bif.bus_rdata = 32'hDEADBEEF;
    bif.d_we      = 1'b0;
    bif.d_sel     = 4'hF;
    bif.d_addr    = 32'h0000_0100;
    bif.d_req     = 1'b1;
    #0;
    if (bif.stall_req_mem) stall_n++;
    tick();
    if (bif.stall_req_mem) stall_n++;
    checks++;
    if ({bif.bus_cyc, bif.bus_we, bif.bus_addr, bif.d_ack} !== {1'b1, 1'b0, 32'h100, 1'b0}) begin
      errors++;
      $display("FAIL load_issue got cyc=%b we=%b addr=%h ack=%b exp 1 0 00000100 0",
               bif.bus_cyc, bif.bus_we, bif.bus_addr, bif.d_ack);
    end
    tick();
    if (bif.stall_req_mem) stall_n++;
    checks++;
    if ({bif.d_ack, bif.d_err, bif.d_rdata, bif.bus_cyc} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL load_ack got ack=%b err=%b rdata=%h cyc=%b exp 1 0 deadbeef 0",
               bif.d_ack, bif.d_err, bif.d_rdata, bif.bus_cyc);
    end
    bif.d_req = 1'b0;
    tick();
    checks++;
    if (bif.d_ack !== 1'b0) begin
      errors++;
      $display("FAIL load_ack_pulse got %b exp 0", bif.d_ack);
    end
    checks++;
    if (stall_n != 2) begin
      errors++;
      $display("FAIL load_stall_cycles got %0d exp 2", stall_n);
    end
  endtask

  task automatic test_contention();
    int cyc = 0;
    slave_wait    = 1;
    bif.bus_rdata = 32'h1111_1111;
    bif.d_we      = 1'b0;
    bif.d_sel     = 4'hF;
    bif.d_addr    = 32'h0000_0300;
    bif.i_addr    = 32'h0000_0200;
    bif.d_req     = 1'b1;
    bif.i_req     = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      cyc = k;
      if (k == 1) begin
        checks++;
        if ({bif.bus_cyc, bif.bus_addr} !== {1'b1, 32'h300}) begin
          errors++;
          $display("FAIL cont_data_first got cyc=%b addr=%h exp 1 00000300", bif.bus_cyc, bif.bus_addr);
        end
      end
      if (k == 3) begin
        checks++;
        if ({bif.d_ack, bif.d_rdata, bif.bus_cyc} !== {1'b1, 32'h1111_1111, 1'b0}) begin
          errors++;
          $display("FAIL cont_d_ack got ack=%b rdata=%h cyc=%b exp 1 11111111 0",
                   bif.d_ack, bif.d_rdata, bif.bus_cyc);
        end
        bif.d_req     = 1'b0;
        bif.bus_rdata = 32'h2222_2222;
      end
      if (k == 4) begin
        checks++;
        if ({bif.bus_cyc, bif.bus_we, bif.bus_sel, bif.bus_addr} !== {1'b1, 1'b0, 4'hF, 32'h200}) begin
          errors++;
          $display("FAIL cont_fetch_issue got cyc=%b we=%b sel=%h addr=%h exp 1 0 f 00000200",
                   bif.bus_cyc, bif.bus_we, bif.bus_sel, bif.bus_addr);
        end
      end
      if (bif.i_ack) break;
    end
    checks++;
    if ({cyc, bif.i_ack, bif.i_rdata} !== {32'd6, 1'b1, 32'h2222_2222}) begin
      errors++;
      $display("FAIL cont_i_ack got cycle=%0d ack=%b rdata=%h exp 6 1 22222222",
               cyc, bif.i_ack, bif.i_rdata);
    end
    bif.i_req = 1'b0;
    tick();
  endtask

  task automatic test_store();
    slave_wait    = 2;
    bif.bus_rdata = 32'hFFFF_FFFF;
    bif.d_we      = 1'b1;
    bif.d_sel     = 4'b0011;
    bif.d_addr    = 32'h0000_0400;
    bif.d_wdata   = 32'h1234_ABCD;
    bif.d_req     = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      // Disturb the inputs to show the command is latched, not passed through.
      bif.d_wdata = 32'h0;
      bif.d_sel   = 4'b1111;
      checks++;
      if ({bif.bus_cyc, bif.bus_we, bif.bus_sel, bif.bus_wdata, bif.d_ack} !==
          {1'b1, 1'b1, 4'b0011, 32'h1234_ABCD, 1'b0}) begin
        errors++;
        $display("FAIL store_hold_%0d got cyc=%b we=%b sel=%b wdata=%h ack=%b exp 1 1 0011 1234abcd 0",
                 k, bif.bus_cyc, bif.bus_we, bif.bus_sel, bif.bus_wdata, bif.d_ack);
      end
    end
    tick();
    checks++;
    if ({bif.d_ack, bif.d_err, bif.d_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL store_ack got ack=%b err=%b rdata=%h exp 1 0 00000000",
               bif.d_ack, bif.d_err, bif.d_rdata);
    end
    bif.d_req = 1'b0;
    bif.d_we  = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int cyc_hi = 0;
    slave_wait = -1;
    bif.i_addr = 32'h0000_0500;
    bif.i_req  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bif.bus_cyc) cyc_hi++;
      if (bif.i_ack) break;
    end
    checks++;
    if ({cyc_hi, bif.i_ack, bif.i_err, bif.i_rdata, bif.bus_cyc} !== {32'd4, 1'b1, 1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_abort got cyc_hi=%0d ack=%b err=%b rdata=%h cyc=%b exp 4 1 1 00000000 0",
               cyc_hi, bif.i_ack, bif.i_err, bif.i_rdata, bif.bus_cyc);
    end
    bif.i_req = 1'b0;
    tick();
    checks++;
    if ({bif.bus_cyc, bif.i_ack, bif.i_err} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_idle got %b exp 000", {bif.bus_cyc, bif.i_ack, bif.i_err});
    end
  endtask

  task automatic test_ack_at_timeout();
    // Ack in the 4th grant cycle lands on the expiry edge and must win.
    slave_wait    = 3;
    bif.bus_rdata = 32'h5A5A_0F0F;
    bif.i_addr    = 32'h0000_0900;
    bif.i_req     = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    checks++;
    if ({bif.i_ack, bif.i_err, bif.i_rdata} !== {1'b1, 1'b0, 32'h5A5A_0F0F}) begin
      errors++;
      $display("FAIL ack_at_timeout got ack=%b err=%b rdata=%h exp 1 0 5a5a0f0f",
               bif.i_ack, bif.i_err, bif.i_rdata);
    end
    bif.i_req = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    slave_wait    = 2;
    bif.bus_rdata = 32'hCAFE_F00D;
    bif.d_we      = 1'b0;
    bif.d_sel     = 4'hF;
    bif.d_addr    = 32'h0000_0600;
    bif.i_addr    = 32'h0000_0700;
    bif.d_req     = 1'b1;
    bif.i_req     = 1'b1;
    tick();
    tick();
    bif.d_req = 1'b0;
    tick();
    checks++;
    if ({bif.bus_cyc, bif.bus_addr} !== {1'b1, 32'h600}) begin
      errors++;
      $display("FAIL flush_bus_held got cyc=%b addr=%h exp 1 00000600", bif.bus_cyc, bif.bus_addr);
    end
    tick();
    checks++;
    if ({bif.bus_cyc, bif.d_ack, bif.i_ack} !== 3'b000) begin
      errors++;
      $display("FAIL flush_no_ack got %b exp 000", {bif.bus_cyc, bif.d_ack, bif.i_ack});
    end
    slave_wait = 0;
    tick();
    checks++;
    if ({bif.bus_cyc, bif.bus_addr} !== {1'b1, 32'h700}) begin
      errors++;
      $display("FAIL flush_fetch_grant got cyc=%b addr=%h exp 1 00000700", bif.bus_cyc, bif.bus_addr);
    end
    tick();
    checks++;
    if ({bif.i_ack, bif.i_rdata, bif.d_ack} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
      errors++;
      $display("FAIL flush_fetch_ack got iack=%b rdata=%h dack=%b exp 1 cafef00d 0",
               bif.i_ack, bif.i_rdata, bif.d_ack);
    end
    bif.i_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    slave_wait = -1;
    bif.i_addr = 32'h0000_0800;
    bif.i_req  = 1'b1;
    tick();
    tick();
    rst       = 1'b1;
    bif.i_req = 1'b0;
    tick();
    checks++;
    if ({bif.bus_cyc, bif.i_ack, bif.i_err, bif.bus_addr} !== {3'b000, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid got cyc=%b ack=%b err=%b addr=%h exp 0 0 0 00000000",
               bif.bus_cyc, bif.i_ack, bif.i_err, bif.bus_addr);
    end
    rst         = 1'b0;
    slave_force = 1'b1;
    tick();
    tick();
    slave_force = 1'b0;
    checks++;
    if ({bif.bus_cyc, bif.i_ack, bif.d_ack} !== 3'b000) begin
      errors++;
      $display("FAIL idle_ack_ignored got %b exp 000", {bif.bus_cyc, bif.i_ack, bif.d_ack});
    end
    tick();
  endtask

  initial begin
    bif.i_req     = 1'b0;
    bif.i_addr    = 32'h0;
    bif.d_req     = 1'b0;
    bif.d_we      = 1'b0;
    bif.d_sel     = 4'h0;
    bif.d_addr    = 32'h0;
    bif.d_wdata   = 32'h0;
    bif.bus_rdata = 32'h0;
    test_reset();
    test_zero_wait_load();
    test_contention();
    test_store();
    test_timeout();
    test_ack_at_timeout();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
